md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
// - Multi-cycle multiply/divide unit in the E stage; owns the architectural HI/LO registers.
// - Executes mult/multu/div/divu, mthi/mtlo and mfhi/mflo.
// - Feeds E_Busy to the hazard unit, which stalls any md-class instruction in D while (E_Start | E_Busy).
// - The hazard unit's stall (D_REG en=0, E_REG clr=1) guarantees no new start is issued while busy.
// PARAMETERS
// - MULT_CYCLES  5   busy cycles for mult/multu (>=1)
// - DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
// - clk       in   1   rising-edge clock
// - reset     in   1   asynchronous, active-high reset
// - E_MDOp    in   4   operation code (md_defs.v), valid in E
// - E_Start   in   1   one-cycle pulse: launch mult/multu/div/divu this cycle
// - E_RS      in   32  forwarded rs operand
// - E_RT      in   32  forwarded rt operand
// - E_MDOut   out  32  mfhi/mflo read data (HI or LO), else 0
// - E_Busy    out  1   operation in flight
// BEHAVIOUR
// - Reset (async, any time incl. mid-operation): HI=0, LO=0, cnt=0, E_Busy=0, pending result discarded.
// - Idle (cnt==0):
//   - E_Start=1 with a mult/div op: compute the full result into tmp_hi/tmp_lo on that edge.
//     - Load cnt with MULT_CYCLES or DIV_CYCLES.
//     - E_Busy rises the next cycle.
//   - E_Start with a non-md op: ignored.
// - Busy (cnt>0): cnt decrements each edge.
//   - On the edge where cnt goes 1->0: HI<=tmp_hi, LO<=tmp_lo, E_Busy falls.
//   - E_Busy is high for exactly N cycles after the start cycle.
// - Results are not visible until busy ends. mfhi/mflo during busy returns the old HI/LO; the hazard unit prevents this.
// - E_Start while busy: ignored; the in-flight op completes unchanged.
// - mthi/mtlo write E_RS into HI/LO at the edge, only when idle and E_Start=0; ignored while busy.
// - mfhi/mflo: E_MDOut = HI or LO combinationally (0-cycle latency); E_MDOut=0 for any other op.
// - Arithmetic rules:
//   - mult: 64-bit signed product; multu: unsigned product; {HI,LO}=product.
//   - div: LO=signed quotient (truncate toward 0), HI=remainder (sign of dividend).
//   - divu: unsigned quotient/remainder, same HI/LO placement.
//   - Divide by zero: HI/LO unchanged; busy timing still DIV_CYCLES.
//   - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
// - No state machine beyond idle/busy (cnt==0 / cnt!=0); cnt width = $clog2(max(MULT_CYCLES,DIV_CYCLES))+1.
// STRUCTURE
// - Shared md_defs.v provides:
//   - MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO localparams.
//   - md_op/md_start decode used by the Controller and the hazard unit.
// - Single flat module; no sub-module is warranted.
// - Hazard-unit contract: D md-class instruction stalls when (E_Start | E_Busy).
// TESTING
// - mult 0xFFFFFFFF*0x00000002: E_Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
// - multu 0xFFFFFFFF*0x00000002: HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
// - div -7/2: E_Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; mflo next cycle outputs 0xFFFFFFFD.
// - mthi 0x12345678, mtlo 0x9 then divu 5/0: busy 10 cycles; HI=0x12345678 and LO=0x9 unchanged.
// - reset pulse at busy cycle 3 of a div: E_Busy=0, HI=LO=0 immediately; a subsequent mult works normally.
// - E_Start(mult) issued during a running div: ignored; div result lands at cycle 10 and busy falls once.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared multiply/divide definitions: operation codes, start decode and
// the arithmetic helpers used to pre-compute HI/LO results.
package md_unit_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    // True for the operations that occupy the unit for several cycles.
    function automatic logic md_start(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // 64-bit product; signed operands are sign-extended so the low 64 bits
    // of the wide product are the two's-complement result.
    function automatic logic [63:0] md_multiply(input logic [31:0] a,
                                                input logic [31:0] b,
                                                input logic        sgn);
        logic [63:0] a_ext;
        logic [63:0] b_ext;
        a_ext = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        return a_ext * b_ext;
    endfunction

    // Returns {remainder, quotient}. Signed division works on magnitudes so
    // 0x80000000 / -1 wraps cleanly to quotient 0x80000000, remainder 0.
    // The quotient truncates toward zero and the remainder takes the
    // dividend's sign. A zero divisor yields 0 (the caller keeps HI/LO).
    function automatic logic [63:0] md_divide(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic        sgn);
        logic        a_neg;
        logic        b_neg;
        logic [31:0] a_mag;
        logic [31:0] b_mag;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        logic [31:0] q;
        logic [31:0] r;
        a_neg = sgn & a[31];
        b_neg = sgn & b[31];
        a_mag = a_neg ? (32'd0 - a) : a;
        b_mag = b_neg ? (32'd0 - b) : b;
        if (b_mag == 32'd0) begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        q = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        r = a_neg ? (32'd0 - r_mag) : r_mag;
        return {r, q};
    endfunction

endpackage

// File: rtl/md_unit.sv
// E-stage multiply/divide unit. Computes the full result on the start edge,
// holds it in tmp_hi/tmp_lo, and commits it to HI/LO when the busy counter
// expires, so results appear with the latency of an iterative unit.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDOp,
    input  logic        E_Start,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    output logic [31:0] E_MDOut,
    output logic        E_Busy
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      tmp_hi_q;
    logic [31:0]      tmp_lo_q;

    logic [63:0]      result_d;
    logic [CNT_W-1:0] cnt_load_d;
    logic             is_mult_d;

    // Select the pending result and busy length for the operation in E.
    always_comb begin
        result_d   = {hi_q, lo_q};
        cnt_load_d = CNT_W'(DIV_CYCLES);
        is_mult_d  = (E_MDOp == MD_MULT) || (E_MDOp == MD_MULTU);
        if (is_mult_d) begin
            result_d   = md_multiply(E_RS, E_RT, E_MDOp == MD_MULT);
            cnt_load_d = CNT_W'(MULT_CYCLES);
        end else if (E_RT != 32'd0) begin
            // Divide by zero keeps the current HI/LO as the "result".
            result_d = md_divide(E_RS, E_RT, E_MDOp == MD_DIV);
        end
    end

    // Idle/busy sequencing, result commit and mthi/mtlo writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            tmp_hi_q <= '0;
            tmp_lo_q <= '0;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                hi_q <= tmp_hi_q;
                lo_q <= tmp_lo_q;
            end
        end else if (E_Start) begin
            if (md_start(E_MDOp)) begin
                cnt_q    <= cnt_load_d;
                tmp_hi_q <= result_d[63:32];
                tmp_lo_q <= result_d[31:0];
            end
        end else begin
            if (E_MDOp == MD_MTHI) hi_q <= E_RS;
            if (E_MDOp == MD_MTLO) lo_q <= E_RS;
        end
    end

    // Zero-latency HI/LO read port; busy is simply a non-zero counter.
    always_comb begin
        E_MDOut = 32'd0;
        if (E_MDOp == MD_MFHI) E_MDOut = hi_q;
        if (E_MDOp == MD_MFLO) E_MDOut = lo_q;
        E_Busy = (cnt_q != '0);
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, arithmetic corner cases, reset
// abort, and ignored starts / moves while busy.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_MDOp;
    logic        E_Start;
    logic [31:0] E_RS;
    logic [31:0] E_RT;
    logic [31:0] E_MDOut;
    logic        E_Busy;

    int checks = 0;
    int errors = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .E_MDOp  (E_MDOp),
        .E_Start (E_Start),
        .E_RS    (E_RS),
        .E_RT    (E_RT),
        .E_MDOut (E_MDOut),
        .E_Busy  (E_Busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read HI, LO and the idle output combinationally within one cycle.
    task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        E_Start = 1'b0;
        E_MDOp  = MD_MFHI;
        #1 check_eq({tag, "_hi"}, E_MDOut, hi);
        E_MDOp  = MD_MFLO;
        #1 check_eq({tag, "_lo"}, E_MDOut, lo);
        E_MDOp  = MD_NONE;
        #1 check_eq({tag, "_none"}, E_MDOut, 32'd0);
        $display("txn %s: HI=0x%08h LO=0x%08h", tag, hi, lo);
    endtask

    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        E_MDOp  = op;
        E_RS    = a;
        E_RT    = b;
        E_Start = 1'b1;
        tick();
        E_Start = 1'b0;
        E_MDOp  = MD_NONE;
    endtask

    // Count cycles in which busy is sampled high; bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (E_Busy && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] v);
        E_MDOp  = op;
        E_RS    = v;
        E_Start = 1'b0;
        tick();
        E_MDOp  = MD_NONE;
    endtask

    int n;
    int m;

    initial begin
        reset   = 1'b1;
        E_MDOp  = MD_NONE;
        E_Start = 1'b0;
        E_RS    = '0;
        E_RT    = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_eq("rst_busy", 32'(E_Busy), 32'd0);
        read_hilo("rst", 32'h0, 32'h0);

        // mult signed
        launch(MD_MULT, 32'hFFFFFFFF, 32'h2);
        wait_idle(n);
        check_eq("mult_cycles", n, 5);
        read_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);

        // multu
        launch(MD_MULTU, 32'hFFFFFFFF, 32'h2);
        wait_idle(n);
        check_eq("multu_cycles", n, 5);
        read_hilo("multu", 32'h00000001, 32'hFFFFFFFE);

        // div -7/2, old LO still visible during busy
        launch(MD_DIV, 32'hFFFFFFF9, 32'h2);
        E_MDOp = MD_MFLO;
        #1 check_eq("div_old_lo", E_MDOut, 32'hFFFFFFFE);
        E_MDOp = MD_NONE;
        wait_idle(n);
        check_eq("div_cycles", n, 10);
        read_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

        // mthi/mtlo then divu by zero
        move_to(MD_MTHI, 32'h12345678);
        move_to(MD_MTLO, 32'h9);
        read_hilo("mtx", 32'h12345678, 32'h9);
        launch(MD_DIVU, 32'h5, 32'h0);
        wait_idle(n);
        check_eq("divz_cycles", n, 10);
        read_hilo("divz", 32'h12345678, 32'h9);

        // reset at busy cycle 3 of a div
        launch(MD_DIV, 32'd100, 32'd7);
        tick();
        tick();
        #1 reset = 1'b1;
        #1 check_eq("rstmid_busy", 32'(E_Busy), 32'd0);
        read_hilo("rstmid", 32'h0, 32'h0);
        reset = 1'b0;
        repeat (12) tick();
        check_eq("rstmid_idle", 32'(E_Busy), 32'd0);
        read_hilo("rstmid_late", 32'h0, 32'h0);
        launch(MD_MULT, 32'd7, 32'hFFFFFFFD);
        wait_idle(n);
        check_eq("mult2_cycles", n, 5);
        read_hilo("mult2", 32'hFFFFFFFF, 32'hFFFFFFEB);

        // mthi while busy is ignored
        launch(MD_MULTU, 32'h00010000, 32'h00010000);
        move_to(MD_MTHI, 32'hDEADBEEF);
        wait_idle(n);
        check_eq("mthi_busy_cycles", n, 4);
        read_hilo("mthi_busy", 32'h1, 32'h0);

        // mult start during a running div is ignored
        launch(MD_DIV, 32'd100, 32'd7);
        tick();
        tick();
        E_MDOp  = MD_MULT;
        E_RS    = 32'd3;
        E_RT    = 32'd4;
        E_Start = 1'b1;
        tick();
        E_Start = 1'b0;
        E_MDOp  = MD_NONE;
        wait_idle(m);
        check_eq("overlap_cycles", 3 + m, 10);
        repeat (6) tick();
        check_eq("overlap_idle", 32'(E_Busy), 32'd0);
        read_hilo("overlap", 32'd2, 32'd14);

        // signed overflow division
        launch(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        read_hilo("divovf", 32'h0, 32'h80000000);

        // unsigned view of the same operands
        launch(MD_DIVU, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        read_hilo("divu_big", 32'h80000000, 32'h0);

        // 7 / -2: quotient toward zero, remainder sign of dividend
        launch(MD_DIV, 32'd7, 32'hFFFFFFFE);
        wait_idle(n);
        read_hilo("div_negdiv", 32'h1, 32'hFFFFFFFD);

        // start with a non-md op is ignored, and mthi with start is not a move
        launch(MD_MTHI, 32'h55, 32'h0);
        check_eq("nonmd_busy", 32'(E_Busy), 32'd0);
        read_hilo("nonmd", 32'h1, 32'hFFFFFFFD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
